uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Next-generation UART transmitter: runtime-configurable frame format (5..MAX_DATA_BITS data bits,
//  none/even/odd parity, 1 or 2 stop bits), integer baud divisor, and a FIFO front end with valid/ready.
//  Sits between the register/bus side (pushes characters) and the TX pin.
// PARAMETERS
//  MAX_DATA_BITS  9   widest supported character; data_bits is clamped to [5, MAX_DATA_BITS]
//  FIFO_DEPTH     16  TX FIFO entries; must be a power of 2, >= 2
//  DIV_W          16  width of baud_div
// PORTS
//  clk          in   1               system clock; all logic on posedge
//  rst          in   1               synchronous, active-high reset
//  baud_div     in   DIV_W           clocks per bit; values < 2 are treated as 2
//  data_bits    in   4               data bits per frame; < 5 -> 5, > MAX_DATA_BITS -> MAX_DATA_BITS
//  parity_mode  in   2               00 none, 01 even, 10 odd, 11 none
//  two_stop     in   1               0 = 1 stop bit, 1 = 2 stop bits
//  tx_en        in   1               permits starting new frames
//  wr_data      in   MAX_DATA_BITS   character to enqueue; bits above data_bits are ignored on send
//  wr_valid     in   1               push request
//  wr_ready     out  1               = !fifo_full
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  occupied entries
//  busy         out  1               1 whenever state != IDLE
//  TX           out  1               serial line; idle high
// BEHAVIOUR
//  Reset: TX=1, busy=0, fifo_count=0, wr_ready=1, FSM=IDLE, FIFO flushed (pointers to 0). Applies mid-frame.
//  FIFO: push on wr_valid&&wr_ready. Pop when FSM launches a frame. No fall-through: a push into a full FIFO
//   is not accepted, even with a simultaneous pop. Push+pop in the same cycle: count unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  Launch condition L = tx_en && fifo_count != 0.
//  FSM: IDLE -> START (on L) -> DATA -> [PARITY if parity enabled] -> STOP -> IDLE or START.
//   - On launch edge: head popped into shift reg; data_bits/parity_mode/two_stop/baud_div latched;
//     TX=0 from that edge. Config changes during a frame have no effect until the next launch.
//   - Every bit (start, each data, parity, each stop) holds TX for exactly the latched baud_div clocks;
//     bit counter reloads to baud_div-1 and counts down to 0.
//   - DATA: LSB first, latched data_bits bits.
//   - PARITY: even -> XOR of sent data bits; odd -> its inverse.
//   - STOP: TX=1 for 1 or 2 bit times. On the final clock of the last stop bit: if L, go straight to
//     START (back-to-back, no idle gap); else IDLE.
//  Frame length = (1 + N + P + S) * baud_div clocks (N data, P 0/1, S 1/2).
//  tx_en low mid-frame: current frame completes; no further launch.
//  busy=1 from the launch edge through the final stop-bit clock; 0 in IDLE.
//  TX is registered (no combinational path from inputs to TX).
// TESTING
//  1 Assert rst 2 clocks -> TX=1, busy=0, fifo_count=0, wr_ready=1.
//  2 baud_div=4, 8N1, tx_en=1, push 0x15 -> TX: 0 for 4 clks, then 1,0,1,0,1,0,0,0 (4 clks each),
//    then 1 for 4; busy high exactly 40 clks.
//  3 baud_div=2, 7 bits, push 0x07 with even/2-stop -> parity bit 1 and 2 stop bits;
//    odd/1-stop -> parity 0. Frame lengths 22 and 20 clks.
//  4 tx_en=0, push 17 words -> wr_ready low after 16th, 17th not stored, count=16.
//    Set tx_en=1 -> 16 frames in order, each start bit immediately after the previous stop bit.
//  5 Change data_bits/baud_div mid-frame and drop tx_en mid-frame -> current frame keeps the old format
//    and completes; the next frame is not launched until tx_en=1, then uses the new format.
//  6 rst pulsed during a data bit with 3 queued -> TX=1 and busy=0 after that edge, count=0,
//    no further frames.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO front end. Frame format, parity and baud divisor
// are sampled when a frame launches and held for the whole frame.
module uart_tx_fifo #(
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 16,
    parameter int DIV_W         = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DIV_W-1:0]                baud_div,
    input  logic [3:0]                      data_bits,
    input  logic [1:0]                      parity_mode,
    input  logic                            two_stop,
    input  logic                            tx_en,
    input  logic [MAX_DATA_BITS-1:0]        wr_data,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            busy,
    output logic                            TX
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and pointers
    logic [MAX_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q;

    // frame engine state
    state_t                   state_q;
    logic                     tx_q, busy_q;
    logic [MAX_DATA_BITS-1:0] sh_q;
    logic [3:0]               nbits_q, bidx_q;
    logic                     par_en_q, par_bit_q, two_q, stop2_q;
    logic [DIV_W-1:0]         div_q, cnt_q;

    // combinational helpers
    logic                     push_d, launch_d, frame_end_d, par_bit_d;
    logic [3:0]               nbits_d;
    logic [DIV_W-1:0]         div_d;
    logic [MAX_DATA_BITS-1:0] mask_d, head_d;

    assign wr_ready   = (count_q != CNT_W'(FIFO_DEPTH));
    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign TX         = tx_q;

    always_comb begin
        push_d  = wr_valid && wr_ready;
        nbits_d = data_bits;
        if (data_bits < 4'd5)
            nbits_d = 4'd5;
        else if (data_bits > 4'(MAX_DATA_BITS))
            nbits_d = 4'(MAX_DATA_BITS);
        div_d = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
        mask_d = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++)
            mask_d[i] = (i < int'(nbits_d));
        // unsent high bits are dropped here so they never leak into parity
        head_d      = mem_q[rd_ptr_q] & mask_d;
        par_bit_d   = (^head_d) ^ (parity_mode == 2'b10);
        frame_end_d = (state_q == S_STOP) && (cnt_q == '0) && (!two_q || stop2_q);
        launch_d    = tx_en && (count_q != '0) && ((state_q == S_IDLE) || frame_end_d);
    end

    always_ff @(posedge clk) begin
        if (push_d)
            mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_d)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (launch_d)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_d, launch_d})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            sh_q      <= '0;
            nbits_q   <= 4'd5;
            bidx_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            two_q     <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= DIV_W'(2);
            cnt_q     <= '0;
        end else if (launch_d) begin
            // covers both a launch from idle and a back-to-back launch off the last stop clock
            state_q   <= S_START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            sh_q      <= head_d;
            nbits_q   <= nbits_d;
            bidx_q    <= '0;
            par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_q <= par_bit_d;
            two_q     <= two_stop;
            stop2_q   <= 1'b0;
            div_q     <= div_d;
            cnt_q     <= div_d - DIV_W'(1);
        end else if (state_q != S_IDLE && cnt_q != '0) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                S_START: begin
                    state_q <= S_DATA;
                    tx_q    <= sh_q[0];
                    sh_q    <= sh_q >> 1;
                    bidx_q  <= '0;
                    cnt_q   <= div_q - DIV_W'(1);
                end
                S_DATA: begin
                    cnt_q <= div_q - DIV_W'(1);
                    if (bidx_q == nbits_q - 4'd1) begin
                        stop2_q <= 1'b0;
                        if (par_en_q) begin
                            state_q <= S_PARITY;
                            tx_q    <= par_bit_q;
                        end else begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        tx_q   <= sh_q[0];
                        sh_q   <= sh_q >> 1;
                        bidx_q <= bidx_q + 4'd1;
                    end
                end
                S_PARITY: begin
                    state_q <= S_STOP;
                    tx_q    <= 1'b1;
                    stop2_q <= 1'b0;
                    cnt_q   <= div_q - DIV_W'(1);
                end
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (two_q && !stop2_q) begin
                        stop2_q <= 1'b1;
                        cnt_q   <= div_q - DIV_W'(1);
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
